reg_writeback: RTL and testbench

Writeback stage that is the sole driver of the CPU register file's single write port (`reg_wr_dest`/`reg_wr_data`/`reg_wr_en`). It merges fixed-latency ALU results, which can never be stalled, with variable-latency memory load results, which are buffered in a small killable FIFO behind a valid/ready handshake. It emits at most one write per cycle, drops writes to r0, and enforces write-after-write ordering. A starvation counter requests a one-cycle ALU bubble so that buffered loads always drain.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_fifo.sv | 91 +++++++++
 rtl/reg_writeback.sv | 147 ++++++++++++++
 tb/tb_reg_writeback.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types and widths for the writeback path.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  // One pending register write; live=0 means it was superseded and must not be written.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Killable load-result FIFO: parallel kill-by-dest, head peek, extra-MSB pointers.
// Optional feature macro: REG_WB_BYPASS_EN adds a youngest-live-entry lookup port.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_dest,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head
`ifdef REG_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] lk_addr,
  output logic                  lk_hit,
  output logic [DATA_W-1:0]     lk_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  wb_entry_t   mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next storage contents: kill matching entries, then write the (possibly pre-killed) push.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && (mem_q[i].dest == kill_dest)) mem_d[i].live = 1'b0;
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]]      = push_entry;
      mem_d[wr_ptr_q[AW-1:0]].live = push_entry.live && !(kill_en && (push_entry.dest == kill_dest));
    end
  end

  // Next pointer values; a pop on an empty FIFO is ignored.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push && !full);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop && !empty);
  end

  // Pointer registers (control, reset to empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents outside the head..tail window are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef REG_WB_BYPASS_EN
  logic [AW:0]   count;
  logic [AW-1:0] idx;
  assign count = wr_ptr_q - rd_ptr_q;

  // Scan oldest to youngest so the last live match is the youngest one.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q[AW-1:0] + AW'(i);
      if (((AW+1)'(i) < count) && mem_q[idx].live && (mem_q[idx].dest == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback: ALU results always win, buffered loads fill idle slots.
// Optional feature macro: REG_WB_BYPASS_EN enables the combinational bypass lookup.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  alu_stall,
  output logic                  reg_wr_en,
  output logic [REG_ADDR_W-1:0] reg_wr_dest,
  output logic [DATA_W-1:0]     reg_wr_data,
  input  logic [REG_ADDR_W-1:0] byp_addr,
  output logic                  byp_hit,
  output logic [DATA_W-1:0]     byp_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic                  alu_wr, push, pop, full, empty;
  wb_entry_t             push_entry, head;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [REG_ADDR_W-1:0] reg_wr_dest_q, reg_wr_dest_d;
  logic [DATA_W-1:0]     reg_wr_data_q, reg_wr_data_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  alu_stall_q, alu_stall_d;
`ifdef REG_WB_BYPASS_EN
  logic                  fifo_hit;
  logic [DATA_W-1:0]     fifo_data;
`endif

  // Writes to r0 are meaningless, so an ALU result to r0 leaves the port free.
  assign alu_wr     = alu_valid && (alu_dest != '0);
  assign mem_ready  = !full && !rst;
  assign push       = mem_valid && mem_ready && (mem_dest != '0);
  assign pop        = !alu_wr && !empty;
  assign push_entry = {1'b1, mem_dest, mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (alu_wr),
    .kill_dest  (alu_dest),
    .full       (full),
    .empty      (empty),
    .head       (head)
`ifdef REG_WB_BYPASS_EN
    ,
    .lk_addr    (byp_addr),
    .lk_hit     (fifo_hit),
    .lk_data    (fifo_data)
`endif
  );

  // Select this cycle's single write: ALU first, else a live FIFO head.
  always_comb begin
    reg_wr_en_d   = 1'b0;
    reg_wr_dest_d = '0;
    reg_wr_data_d = '0;
    if (alu_wr) begin
      reg_wr_en_d   = 1'b1;
      reg_wr_dest_d = alu_dest;
      reg_wr_data_d = alu_data;
    end else if (pop && head.live) begin
      reg_wr_en_d   = 1'b1;
      reg_wr_dest_d = head.dest;
      reg_wr_data_d = head.data;
    end
  end

  // Count cycles the ALU blocks a waiting load; request a one-cycle bubble at the limit.
  always_comb begin
    starve_d    = starve_q;
    alu_stall_d = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q == CW'(STARVE_LIMIT - 1)) begin
      starve_d    = '0;
      alu_stall_d = 1'b1;
    end else begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Registered write port, stall request and starve counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en_q   <= 1'b0;
      reg_wr_dest_q <= '0;
      reg_wr_data_q <= '0;
      starve_q      <= '0;
      alu_stall_q   <= 1'b0;
    end else begin
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_dest_q <= reg_wr_dest_d;
      reg_wr_data_q <= reg_wr_data_d;
      starve_q      <= starve_d;
      alu_stall_q   <= alu_stall_d;
    end
  end

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_dest = reg_wr_dest_q;
  assign reg_wr_data = reg_wr_data_q;
  assign alu_stall   = alu_stall_q;

`ifdef REG_WB_BYPASS_EN
  // Youngest pending value: incoming ALU result, then output register, then FIFO.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_addr != '0) begin
      if (alu_wr && (alu_dest == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = alu_data;
      end else if (reg_wr_en_q && (reg_wr_dest_q == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = reg_wr_data_q;
      end else if (fifo_hit) begin
        byp_hit  = 1'b1;
        byp_data = fifo_data;
      end
    end
  end
`else
  logic unused_byp_addr;
  assign unused_byp_addr = ^byp_addr;
  assign byp_hit         = 1'b0;
  assign byp_data        = '0;
`endif

  // Upstream must honour the bubble; an ALU result during alu_stall is a protocol violation.
  a_no_alu_during_stall: assert property (@(posedge clk) disable iff (rst) !(alu_stall && alu_valid));

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        alu_stall;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_dest;
  logic [15:0] reg_wr_data;
  logic [2:0]  byp_addr;
  logic        byp_hit;
  logic [15:0] byp_data;

  int nvec  = 0;
  int nfail = 0;

  reg_writeback #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_dest    (mem_dest),
    .mem_data    (mem_data),
    .alu_stall   (alu_stall),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_dest (reg_wr_dest),
    .reg_wr_data (reg_wr_data),
    .byp_addr    (byp_addr),
    .byp_hit     (byp_hit),
    .byp_data    (byp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [2:0] d, input logic [15:0] x);
    alu_valid = v; alu_dest = d; alu_data = x;
  endtask

  task automatic set_mem(input logic v, input logic [2:0] d, input logic [15:0] x);
    mem_valid = v; mem_dest = d; mem_data = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_alu(1'b0, 3'd0, 16'h0); set_mem(1'b0, 3'd0, 16'h0); byp_addr = 3'd0;
    tick(); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b0, 3'd0, 16'h0}) begin nfail++; $display("FAIL reset_wr_port got=%h want=0", {reg_wr_en, reg_wr_dest, reg_wr_data}); end
    nvec++; if (alu_stall !== 1'b0) begin nfail++; $display("FAIL reset_stall got=%b want=0", alu_stall); end
    nvec++; if (mem_ready !== 1'b0) begin nfail++; $display("FAIL reset_mem_ready_in_rst got=%b want=0", mem_ready); end
    rst = 1'b0; #1;
    nvec++; if (mem_ready !== 1'b1) begin nfail++; $display("FAIL reset_mem_ready_after got=%b want=1", mem_ready); end
  endtask

  task automatic test_alu_only();
    set_alu(1'b1, 3'd3, 16'h1234); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd3, 16'h1234}) begin nfail++; $display("FAIL alu_write got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd3, 16'h1234}); end
    set_alu(1'b1, 3'd0, 16'h5678); tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL alu_r0_dropped got=%b want=0", reg_wr_en); end
    set_alu(1'b0, 3'd0, 16'h0); tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL alu_idle got=%b want=0", reg_wr_en); end
  endtask

  task automatic test_loads();
    logic [15:0] d;
    for (int i = 1; i <= 4; i++) begin
      set_alu(1'b1, 3'd7, 16'h7000 + 16'(i));
      set_mem(1'b1, 3'(i), 16'hA0 + 16'(i));
      tick();
    end
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd7, 16'h7004}) begin nfail++; $display("FAIL load_alu_priority got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd7, 16'h7004}); end
    nvec++; if (mem_ready !== 1'b0) begin nfail++; $display("FAIL load_full_ready got=%b want=0", mem_ready); end
    set_mem(1'b1, 3'd6, 16'hDEAD);
    tick();
    set_alu(1'b0, 3'd0, 16'h0);
    set_mem(1'b0, 3'd0, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      d = 16'hA0 + 16'(i);
      nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'(i), d}) begin nfail++; $display("FAIL load_drain_%0d got=%h want=%h", i, {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'(i), d}); end
    end
    tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL load_drained_no_write got=%b want=0", reg_wr_en); end
  endtask

  task automatic test_kill();
    set_alu(1'b1, 3'd7, 16'h0777); set_mem(1'b1, 3'd5, 16'hBEEF); tick();
    set_alu(1'b1, 3'd5, 16'h0001); set_mem(1'b0, 3'd0, 16'h0); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd5, 16'h0001}) begin nfail++; $display("FAIL kill_alu_write got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd5, 16'h0001}); end
    set_alu(1'b0, 3'd0, 16'h0); tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL kill_dead_pop got=%b want=0", reg_wr_en); end
    tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL kill_empty_after got=%b want=0", reg_wr_en); end
    set_alu(1'b1, 3'd6, 16'h0002); set_mem(1'b1, 3'd6, 16'hCAFE); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd6, 16'h0002}) begin nfail++; $display("FAIL kill_same_cycle_alu got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd6, 16'h0002}); end
    set_alu(1'b0, 3'd0, 16'h0); set_mem(1'b0, 3'd0, 16'h0); tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL kill_same_cycle_dead got=%b want=0", reg_wr_en); end
    tick();
  endtask

  task automatic test_starvation();
    set_alu(1'b1, 3'd7, 16'h0100); set_mem(1'b1, 3'd1, 16'h5555); tick();
    set_mem(1'b0, 3'd0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      set_alu(1'b1, 3'd7, 16'h0100 + 16'(i));
      tick();
      if (i == 7) begin
        nvec++; if (alu_stall !== 1'b0) begin nfail++; $display("FAIL starve_early_stall got=%b want=0", alu_stall); end
      end
      if (i == 8) begin
        nvec++; if (alu_stall !== 1'b1) begin nfail++; $display("FAIL starve_stall got=%b want=1", alu_stall); end
      end
    end
    set_alu(1'b0, 3'd0, 16'h0); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd1, 16'h5555}) begin nfail++; $display("FAIL starve_load_write got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd1, 16'h5555}); end
    nvec++; if (alu_stall !== 1'b0) begin nfail++; $display("FAIL starve_stall_one_cycle got=%b want=0", alu_stall); end
  endtask

  task automatic test_back_to_back();
    set_alu(1'b1, 3'd7, 16'h0700); set_mem(1'b1, 3'd1, 16'h1111); tick();
    set_alu(1'b0, 3'd0, 16'h0);    set_mem(1'b1, 3'd2, 16'h2222); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd1, 16'h1111}) begin nfail++; $display("FAIL b2b_first got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd1, 16'h1111}); end
    set_mem(1'b0, 3'd0, 16'h0); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd2, 16'h2222}) begin nfail++; $display("FAIL b2b_second got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd2, 16'h2222}); end
    tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL b2b_idle got=%b want=0", reg_wr_en); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      set_alu(1'b1, 3'd7, 16'h0900); set_mem(1'b1, 3'(i), 16'hB0 + 16'(i)); tick();
    end
    set_alu(1'b0, 3'd0, 16'h0); set_mem(1'b0, 3'd0, 16'h0);
    rst = 1'b1; tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL rstmid_wr_en got=%b want=0", reg_wr_en); end
    rst = 1'b0; #1;
    nvec++; if (mem_ready !== 1'b1) begin nfail++; $display("FAIL rstmid_mem_ready got=%b want=1", mem_ready); end
    tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL rstmid_no_write_1 got=%b want=0", reg_wr_en); end
    tick();
    nvec++; if (reg_wr_en !== 1'b0) begin nfail++; $display("FAIL rstmid_no_write_2 got=%b want=0", reg_wr_en); end
  endtask

  task automatic test_bypass();
    set_alu(1'b1, 3'd7, 16'h0ABC); set_mem(1'b1, 3'd2, 16'h0BAD); tick();
    set_mem(1'b0, 3'd0, 16'h0);
    byp_addr = 3'd2; #1;
`ifdef REG_WB_BYPASS_EN
    nvec++; if ({byp_hit, byp_data} !== {1'b1, 16'h0BAD}) begin nfail++; $display("FAIL bypass_fifo got=%h want=%h", {byp_hit, byp_data}, {1'b1, 16'h0BAD}); end
    byp_addr = 3'd7; #1;
    nvec++; if ({byp_hit, byp_data} !== {1'b1, 16'h0ABC}) begin nfail++; $display("FAIL bypass_alu got=%h want=%h", {byp_hit, byp_data}, {1'b1, 16'h0ABC}); end
    byp_addr = 3'd0; #1;
    nvec++; if (byp_hit !== 1'b0) begin nfail++; $display("FAIL bypass_r0 got=%b want=0", byp_hit); end
`else
    nvec++; if ({byp_hit, byp_data} !== {1'b0, 16'h0}) begin nfail++; $display("FAIL bypass_tied got=%h want=0", {byp_hit, byp_data}); end
`endif
    byp_addr = 3'd0;
    set_alu(1'b0, 3'd0, 16'h0); tick();
    nvec++; if ({reg_wr_en, reg_wr_dest, reg_wr_data} !== {1'b1, 3'd2, 16'h0BAD}) begin nfail++; $display("FAIL bypass_drain got=%h want=%h", {reg_wr_en, reg_wr_dest, reg_wr_data}, {1'b1, 3'd2, 16'h0BAD}); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_loads();
    test_kill();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
